branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
Sequencing controller for branch resolution in the pipelined CPU. It accepts BEZ/BNEZ/J ops from decode and stalls decode while the 64-bit test operand is still in flight, resolving once the operand arrives via forwarding. It then evaluates zero/non-zero, drives the PC redirect and flushes the wrong-path instructions. It also keeps saturating branch statistics for the host-readable register block.

Parameters:
PC_W, 9, instruction address width
DATA_W, 64, register operand width
FLUSH_CYCLES, 2, cycles flush held high after a taken branch (min 1)
MAX_WAIT, 4, max cycles in WAIT_OPND before timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  decode stage holds a valid instruction
id_bez  in  1  decode op is BEZ
id_bnez  in  1  decode op is BNEZ
id_jump  in  1  decode op is unconditional J
id_target  in  PC_W  branch/jump target from decode
id_rs_hazard  in  1  test register has an older in-flight writer
rf_data  in  DATA_W  register-file read of test register
fwd_valid  in  1  forwarded operand valid this cycle
fwd_data  in  DATA_W  forwarded operand value
stall  out  1  hold PC and IF/ID (combinational)
flush  out  1  squash IF/ID and ID/EX (registered)
pc_load  out  1  one-cycle PC redirect strobe (registered)
pc_target  out  PC_W  redirect address, valid with pc_load
timeout_err  out  1  sticky: operand never arrived
branch_cnt  out  16  resolved branches, saturating
taken_cnt  out  16  taken branches, saturating

Behaviour:
- Reset (async, any state, any cycle): state=IDLE; flush, pc_load, timeout_err = 0; pc_target, branch_cnt, taken_cnt, wait/flush counters = 0. No pulse is emitted for a branch aborted by reset.
- br = id_valid & (id_bez | id_bnez | id_jump). cond = br & ~id_jump.
- Taken rule: zero = ~|operand; taken = id_jump | (bez & zero) | (bnez & ~zero). If BEZ and BNEZ are both set, the branch is always taken. Jump takes priority and needs no operand.
- States: IDLE, WAIT_OPND, FLUSH.
- IDLE:
  - br & (id_jump | ~id_rs_hazard): resolve this cycle using rf_data and latch id_target.
    - Taken: next cycle pc_load=1 and pc_target=target for exactly 1 cycle; flush=1 for FLUSH_CYCLES cycles starting that same cycle; state goes to FLUSH.
    - Not taken: stay in IDLE, no pulses.
  - cond & id_rs_hazard: latch op bits and target, clear the wait counter, go to WAIT_OPND. stall=1 in this same cycle.
- WAIT_OPND:
  - stall=1 continuously.
  - fwd_valid: resolve using fwd_data, same rules and timing as IDLE. fwd_data is ignored unless fwd_valid.
  - Otherwise increment the wait counter. When it reaches MAX_WAIT without fwd_valid: set timeout_err (sticky until reset), treat the branch as not taken, return to IDLE, and do not count the branch.
  - Decode inputs are ignored; the latched values are used.
- FLUSH:
  - flush=1, stall=0. The counter runs FLUSH_CYCLES, then the state returns to IDLE.
  - br during FLUSH is ignored, because that instruction is wrong-path.
- stall = (state==WAIT_OPND) | (state==IDLE & cond & id_rs_hazard). This is combinational; all other outputs are registered.
- Counters: branch_cnt +1 and taken_cnt +1 on the cycle pc_load would be computed, at the resolve decision. Both saturate at 16'hFFFF with no wrap.
- Latency: decision to pc_load is 1 cycle. Hazard-free taken branch: pc_load appears 1 cycle after br.

Test Plan:
- Reset mid-WAIT_OPND: assert reset after 2 wait cycles -> stall=0 immediately, state IDLE, no pc_load, counters 0.
- BEZ, no hazard, rf_data=0, target=0x3A -> next cycle pc_load=1 and pc_target=0x3A for 1 cycle; flush high 2 cycles; branch_cnt=1, taken_cnt=1.
- BNEZ, no hazard, rf_data=0 -> no pc_load, no flush; branch_cnt=1, taken_cnt=0.
  - Repeat with rf_data=64'h8000_0000_0000_0000 -> taken.
- BNEZ with id_rs_hazard; fwd_valid on the 3rd wait cycle with fwd_data=5 -> stall high 3 cycles, then pc_load next cycle.
  - With fwd_valid never asserted -> after MAX_WAIT=4 cycles, timeout_err=1, stall drops, no redirect.
- J with id_rs_hazard=1 and target=0x1FF -> no stall; pc_load next cycle with 0x1FF.
  - A second branch presented during FLUSH is ignored and branch_cnt increments only once.
- Saturation: preload by issuing 65 535 taken branches, then one more -> both counters hold 16'hFFFF.

Source files
------------

// File: rtl/branch_resolve_ctrl_if.sv
// Decode/forwarding-side bundle for the branch resolve controller.
// master drives decode and forwarding inputs; slave is the controller.
`timescale 1ns/1ps
interface branch_resolve_ctrl_if #(
  parameter int PC_W   = 9,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic              id_bez;
  logic              id_bnez;
  logic              id_jump;
  logic [PC_W-1:0]   id_target;
  logic              id_rs_hazard;
  logic [DATA_W-1:0] rf_data;
  logic              fwd_valid;
  logic [DATA_W-1:0] fwd_data;
  logic              stall;
  logic              flush;
  logic              pc_load;
  logic [PC_W-1:0]   pc_target;
  logic              timeout_err;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  taken_cnt;

  modport master (
    output id_valid, id_bez, id_bnez, id_jump, id_target, id_rs_hazard,
           rf_data, fwd_valid, fwd_data,
    input  stall, flush, pc_load, pc_target, timeout_err, branch_cnt, taken_cnt
  );

  modport slave (
    input  id_valid, id_bez, id_bnez, id_jump, id_target, id_rs_hazard,
           rf_data, fwd_valid, fwd_data,
    output stall, flush, pc_load, pc_target, timeout_err, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve: BEZ/BNEZ/J, redirect 1 cycle after decision, flush held FLUSH_CYCLES.
// Stalls decode (combinational) while the test operand is in flight, up to MAX_WAIT cycles.
`timescale 1ns/1ps
module branch_resolve_ctrl #(
  parameter int PC_W         = 9,
  parameter int DATA_W       = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_WAIT     = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_ctrl_if.slave  bus
);
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WC_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_OPND, S_FLUSH} state_t;

  state_t            state;
  logic [FC_W-1:0]   flush_cnt;
  logic [WC_W-1:0]   wait_cnt;
  logic              lat_bez;
  logic              lat_bnez;
  logic [PC_W-1:0]   lat_target;

  logic              br;
  logic              cond;
  logic              resolve_now;
  logic              resolve_taken;
  logic [PC_W-1:0]   resolve_target;

  function automatic logic is_taken(input logic jump, input logic bez, input logic bnez,
                                    input logic [DATA_W-1:0] opnd);
    logic zero;
    zero = ~|opnd;
    return jump | (bez & zero) | (bnez & ~zero);
  endfunction

  always_comb begin
    br             = bus.id_valid & (bus.id_bez | bus.id_bnez | bus.id_jump);
    cond           = br & ~bus.id_jump;
    resolve_now    = 1'b0;
    resolve_taken  = 1'b0;
    resolve_target = bus.id_target;
    if (state == S_IDLE) begin
      resolve_now    = br & (bus.id_jump | ~bus.id_rs_hazard);
      resolve_taken  = is_taken(bus.id_jump, bus.id_bez, bus.id_bnez, bus.rf_data);
    end else if (state == S_WAIT_OPND) begin
      // Only the latched op matters here; fwd_data is meaningless without fwd_valid.
      resolve_now    = bus.fwd_valid;
      resolve_taken  = is_taken(1'b0, lat_bez, lat_bnez, bus.fwd_data);
      resolve_target = lat_target;
    end
  end

  assign bus.stall = (state == S_WAIT_OPND) |
                     ((state == S_IDLE) & cond & bus.id_rs_hazard);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      flush_cnt       <= '0;
      wait_cnt        <= '0;
      lat_bez         <= 1'b0;
      lat_bnez        <= 1'b0;
      lat_target      <= '0;
      bus.flush       <= 1'b0;
      bus.pc_load     <= 1'b0;
      bus.pc_target   <= '0;
      bus.timeout_err <= 1'b0;
      bus.branch_cnt  <= '0;
      bus.taken_cnt   <= '0;
    end else begin
      bus.pc_load <= 1'b0;
      if (resolve_now) begin
        if (~&bus.branch_cnt) bus.branch_cnt <= bus.branch_cnt + CNT_W'(1);
        if (resolve_taken) begin
          if (~&bus.taken_cnt) bus.taken_cnt <= bus.taken_cnt + CNT_W'(1);
          bus.pc_load   <= 1'b1;
          bus.pc_target <= resolve_target;
          bus.flush     <= 1'b1;
          flush_cnt     <= FC_W'(FLUSH_CYCLES - 1);
          state         <= S_FLUSH;
        end else begin
          state <= S_IDLE;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (cond & bus.id_rs_hazard) begin
              lat_bez    <= bus.id_bez;
              lat_bnez   <= bus.id_bnez;
              lat_target <= bus.id_target;
              wait_cnt   <= '0;
              state      <= S_WAIT_OPND;
            end
          end
          S_WAIT_OPND: begin
            // Give up on a lost operand: fall through as not-taken and leave the stats alone.
            if (wait_cnt == WC_W'(MAX_WAIT - 1)) begin
              bus.timeout_err <= 1'b1;
              state           <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + WC_W'(1);
            end
          end
          S_FLUSH: begin
            if (flush_cnt == '0) begin
              bus.flush <= 1'b0;
              state     <= S_IDLE;
            end else begin
              flush_cnt <= flush_cnt - FC_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed vectors plus hand-written hazard/timeout/reset/saturation sequences.
`timescale 1ns/1ps
module tb_branch_resolve_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.PC_W(9), .DATA_W(64), .CNT_W(16)) m_if ();
  branch_resolve_ctrl_if #(.PC_W(9), .DATA_W(64), .CNT_W(4))  s_if ();

  branch_resolve_ctrl #(.PC_W(9), .DATA_W(64), .FLUSH_CYCLES(2), .MAX_WAIT(4), .CNT_W(16))
    dut (.clk(clk), .reset(reset), .bus(m_if.slave));

  // Narrow-counter, single-flush-cycle copy so saturation is reachable quickly.
  branch_resolve_ctrl #(.PC_W(9), .DATA_W(64), .FLUSH_CYCLES(1), .MAX_WAIT(4), .CNT_W(4))
    u_sat (.clk(clk), .reset(reset), .bus(s_if.slave));

  typedef struct {
    logic        valid;
    logic        bez;
    logic        bnez;
    logic        jump;
    logic        hazard;
    logic [63:0] rf;
    logic [8:0]  tgt;
    logic        exp_br;
    logic        exp_tk;
  } vec_t;

  vec_t vecs [8];
  int   errors = 0;
  int   checks = 0;
  int   exp_br = 0;
  int   exp_tk = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_m();
    m_if.id_valid = 1'b0; m_if.id_bez = 1'b0; m_if.id_bnez = 1'b0; m_if.id_jump = 1'b0;
    m_if.id_target = '0; m_if.id_rs_hazard = 1'b0; m_if.rf_data = '0;
    m_if.fwd_valid = 1'b0; m_if.fwd_data = '0;
  endtask

  task automatic idle_s();
    s_if.id_valid = 1'b0; s_if.id_bez = 1'b0; s_if.id_bnez = 1'b0; s_if.id_jump = 1'b0;
    s_if.id_target = '0; s_if.id_rs_hazard = 1'b0; s_if.rf_data = '0;
    s_if.fwd_valid = 1'b0; s_if.fwd_data = '0;
  endtask

  task automatic drive_m(input logic v, input logic bz, input logic bnz, input logic j,
                         input logic hz, input logic [63:0] rf, input logic [8:0] tgt);
    m_if.id_valid = v; m_if.id_bez = bz; m_if.id_bnez = bnz; m_if.id_jump = j;
    m_if.id_rs_hazard = hz; m_if.rf_data = rf; m_if.id_target = tgt;
  endtask

  task automatic check_cnts(input string name);
    check({name, "_branch_cnt"}, 64'(m_if.branch_cnt), 64'(exp_br));
    check({name, "_taken_cnt"},  64'(m_if.taken_cnt),  64'(exp_tk));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                  9'h03A, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,                  9'h010, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 9'h055, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1,                  9'h0A0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h7,                  9'h0C3, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0,                  9'h1FF, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                  9'h044, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h1,                  9'h100, 1'b1, 1'b1};

    reset = 1'b1;
    idle_m();
    idle_s();
    #3;
    check("rst_stall",   64'(m_if.stall), 64'h0);
    check("rst_flush",   64'(m_if.flush), 64'h0);
    check("rst_pc_load", 64'(m_if.pc_load), 64'h0);
    check("rst_pc_tgt",  64'(m_if.pc_target), 64'h0);
    check("rst_timeout", 64'(m_if.timeout_err), 64'h0);
    check_cnts("rst");
    step();
    step();
    reset = 1'b0;
    step();

    // Single-cycle resolves from IDLE.
    for (int i = 0; i < 8; i++) begin
      drive_m(vecs[i].valid, vecs[i].bez, vecs[i].bnez, vecs[i].jump, vecs[i].hazard,
              vecs[i].rf, vecs[i].tgt);
      #1;
      check($sformatf("v%0d_stall", i), 64'(m_if.stall), 64'h0);
      step();
      idle_m();
      if (vecs[i].exp_br) exp_br++;
      if (vecs[i].exp_tk) exp_tk++;
      check($sformatf("v%0d_pc_load", i), 64'(m_if.pc_load), 64'(vecs[i].exp_tk));
      check($sformatf("v%0d_flush", i),   64'(m_if.flush),   64'(vecs[i].exp_tk));
      if (vecs[i].exp_tk)
        check($sformatf("v%0d_pc_target", i), 64'(m_if.pc_target), 64'(vecs[i].tgt));
      check_cnts($sformatf("v%0d", i));
      step();
      check($sformatf("v%0d_pc_load_c2", i), 64'(m_if.pc_load), 64'h0);
      check($sformatf("v%0d_flush_c2", i),   64'(m_if.flush),   64'(vecs[i].exp_tk));
      if (vecs[i].exp_tk) begin
        step();
        check($sformatf("v%0d_flush_c3", i), 64'(m_if.flush), 64'h0);
      end
    end

    // Wrong-path branch offered during FLUSH must be ignored.
    drive_m(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 9'h0AB);
    step();
    exp_br++; exp_tk++;
    drive_m(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 9'h011);
    #1;
    check("fl_pc_load", 64'(m_if.pc_load), 64'h1);
    check("fl_pc_tgt",  64'(m_if.pc_target), 64'h0AB);
    check("fl_stall1",  64'(m_if.stall), 64'h0);
    step();
    check("fl_stall2",  64'(m_if.stall), 64'h0);
    check("fl_flush2",  64'(m_if.flush), 64'h1);
    step();
    idle_m();
    check("fl_flush3",   64'(m_if.flush), 64'h0);
    check("fl_pc_load3", 64'(m_if.pc_load), 64'h0);
    check_cnts("fl");

    // BNEZ behind a hazard, operand forwarded on the third stall cycle.
    drive_m(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 9'h077);
    #1;
    check("hz_stall1", 64'(m_if.stall), 64'h1);
    step();
    idle_m();
    #1;
    check("hz_stall2", 64'(m_if.stall), 64'h1);
    check_cnts("hz_wait");
    step();
    m_if.fwd_valid = 1'b1;
    m_if.fwd_data  = 64'd5;
    #1;
    check("hz_stall3", 64'(m_if.stall), 64'h1);
    step();
    idle_m();
    exp_br++; exp_tk++;
    check("hz_stall4",  64'(m_if.stall), 64'h0);
    check("hz_pc_load", 64'(m_if.pc_load), 64'h1);
    check("hz_pc_tgt",  64'(m_if.pc_target), 64'h077);
    check("hz_flush",   64'(m_if.flush), 64'h1);
    check_cnts("hz");
    step();
    step();
    check("hz_flush_end", 64'(m_if.flush), 64'h0);

    // BEZ behind a hazard whose operand never arrives.
    drive_m(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 9'h0EE);
    #1;
    check("to_stall0", 64'(m_if.stall), 64'h1);
    step();
    idle_m();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("to_stall_w%0d", k + 1), 64'(m_if.stall), 64'h1);
      check($sformatf("to_err_w%0d", k + 1),   64'(m_if.timeout_err), 64'h0);
      step();
    end
    check("to_stall_end", 64'(m_if.stall), 64'h0);
    check("to_err",       64'(m_if.timeout_err), 64'h1);
    check("to_pc_load",   64'(m_if.pc_load), 64'h0);
    check("to_flush",     64'(m_if.flush), 64'h0);
    check_cnts("to");
    step();
    check("to_err_sticky", 64'(m_if.timeout_err), 64'h1);

    // Reset arriving mid-wait aborts the branch silently.
    drive_m(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 9'h033);
    step();
    idle_m();
    step();
    step();
    check("rw_stall_pre", 64'(m_if.stall), 64'h1);
    m_if.fwd_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    exp_br = 0; exp_tk = 0;
    check("rw_stall",   64'(m_if.stall), 64'h0);
    check("rw_timeout", 64'(m_if.timeout_err), 64'h0);
    check("rw_pc_load", 64'(m_if.pc_load), 64'h0);
    check("rw_pc_tgt",  64'(m_if.pc_target), 64'h0);
    check_cnts("rw");
    step();
    idle_m();
    #2;
    reset = 1'b0;
    step();
    check("rw_pc_load2", 64'(m_if.pc_load), 64'h0);
    check("rw_flush2",   64'(m_if.flush), 64'h0);
    check("rw_stall2",   64'(m_if.stall), 64'h0);

    // Saturation on the narrow-counter instance.
    for (int n = 0; n < 17; n++) begin
      s_if.id_valid  = 1'b1;
      s_if.id_jump   = 1'b1;
      s_if.id_target = 9'(n);
      step();
      idle_s();
      check($sformatf("sat%0d_pc_load", n), 64'(s_if.pc_load), 64'h1);
      check($sformatf("sat%0d_pc_tgt", n),  64'(s_if.pc_target), 64'(n));
      check($sformatf("sat%0d_br", n), 64'(s_if.branch_cnt), 64'((n + 1 > 15) ? 15 : n + 1));
      check($sformatf("sat%0d_tk", n), 64'(s_if.taken_cnt),  64'((n + 1 > 15) ? 15 : n + 1));
      step();
      check($sformatf("sat%0d_flush_end", n), 64'(s_if.flush), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
